// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset PC, bubble
// encoding and FSM state encodings.
package fetch_stage_pkg;

    localparam int unsigned DefWidth    = 32;
    localparam logic [31:0] DefResetPc  = 32'h0000_0000;
    localparam logic [31:0] DefNopInstr = 32'h0000_0000;  // sll $0,$0,0

    localparam logic [1:0] PcSrcNone   = 2'b00;
    localparam logic [1:0] PcSrcBranch = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [1:0] {
        StFetch = 2'b00,
        StDrain = 2'b01,
        StHold  = 2'b10
    } fetch_state_e;

    // Jump takes priority over branch when both are flagged.
    function automatic logic is_jump(input logic [1:0] pc_src);
        return pc_src[1];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: request/address held stable until ready; data
// valid in the cycle ready is high (ready may arrive in the request cycle).
interface fetch_stage_if #(
    parameter int unsigned Width = 32
) ();

    logic             req;
    logic [Width-1:0] addr;
    logic [Width-1:0] rdata;
    logic             rdy;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  rdy
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output rdy
    );

endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: loads when enabled, synchronous clear inserts a bubble.
module fetch_stage_if_id #(
    parameter int unsigned      Width    = 32,
    parameter logic [Width-1:0] NopInstr = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [Width-1:0] instr,
    input  logic [Width-1:0] pc_plus4,
    output logic [Width-1:0] instr_q,
    output logic [Width-1:0] pc_plus4_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NopInstr;
            pc_plus4_q <= '0;
        end else if (en) begin
            if (clr) begin
                instr_q    <= NopInstr;
                pc_plus4_q <= '0;
            end else begin
                instr_q    <= instr;
                pc_plus4_q <= pc_plus4;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem read FSM, branch/jump redirect, IF/ID load.
// Optional macro FETCH_SKID_EN adds a one-entry skid buffer and the HOLD state.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned      Width    = DefWidth,
    parameter logic [Width-1:0] ResetPc  = Width'(DefResetPc),
    parameter logic [Width-1:0] NopInstr = Width'(DefNopInstr)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic [1:0]       pc_src_d,
    input  logic [Width-1:0] pc_branch_d,
    input  logic [Width-1:0] pc_jump_d,
    fetch_stage_if.master    imem,
    output logic [Width-1:0] pc_f,
    output logic [Width-1:0] instr_d,
    output logic [Width-1:0] pc_plus4_d,
    output logic             fetch_busy_f
);

    fetch_state_e     state_q, state_d;
    logic [Width-1:0] pc_q, pc_d;
    logic [Width-1:0] redir_pc_q, redir_pc_d;
    logic [Width-1:0] pc_plus4;
    logic [Width-1:0] target;
    logic [Width-1:0] deliver_instr;
    logic             started_q;
    logic             redirect;
    logic             deliver;
`ifdef FETCH_SKID_EN
    logic [Width-1:0] skid_q, skid_d;
`endif

    assign redirect = (pc_src_d != PcSrcNone) && !stall_d;
    assign target   = is_jump(pc_src_d) ? pc_jump_d : pc_branch_d;
    assign pc_plus4 = pc_q + Width'(4);
    assign pc_f     = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
`ifdef FETCH_SKID_EN
        skid_d        = skid_q;
`endif
        imem.req      = 1'b0;
        imem.addr     = pc_q;
        deliver       = 1'b0;
        deliver_instr = imem.rdata;
        fetch_busy_f  = 1'b1;

        // No request is issued until the first clock edge after reset release.
        if (started_q) begin
            unique case (state_q)
                StFetch: begin
                    imem.req     = 1'b1;
                    fetch_busy_f = !imem.rdy;
                    if (redirect) begin
                        if (imem.rdy) begin
                            pc_d = target;
                        end else begin
                            redir_pc_d = target;
                            state_d    = StDrain;
                        end
                    end else if (imem.rdy && !stall_f) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                    end
`ifdef FETCH_SKID_EN
                    else if (imem.rdy) begin
                        skid_d  = imem.rdata;
                        state_d = StHold;
                    end
`endif
                end
                // The outstanding read must complete before the new PC can be requested.
                StDrain: begin
                    imem.req = 1'b1;
                    if (imem.rdy) begin
                        pc_d    = redir_pc_q;
                        state_d = StFetch;
                    end
                end
`ifdef FETCH_SKID_EN
                StHold: begin
                    fetch_busy_f  = 1'b0;
                    deliver_instr = skid_q;
                    if (redirect) begin
                        pc_d    = target;
                        state_d = StFetch;
                    end else if (!stall_f) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = StFetch;
                    end
                end
`endif
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            pc_q       <= ResetPc;
            redir_pc_q <= '0;
            started_q  <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            started_q  <= 1'b1;
`ifdef FETCH_SKID_EN
            skid_q     <= skid_d;
`endif
        end
    end

    fetch_stage_if_id #(
        .Width    (Width),
        .NopInstr (NopInstr)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (!stall_d),
        .clr        (redirect || !deliver),
        .instr      (deliver_instr),
        .pc_plus4   (pc_plus4),
        .instr_q    (instr_d),
        .pc_plus4_q (pc_plus4_d)
    );

`ifndef SYNTHESIS
    // Decode only holds bubbles while draining, so no branch can resolve here.
    drain_no_redirect: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StDrain) |-> !redirect)
        else $error("redirect observed while draining");
`endif

endmodule
